alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Sequencing front/back end wrapped around the combinational ALU (16-bit operands, 3-bit opcode, 1-bit mode, 32-bit result, za/zb/eq/gt/lt flags).
- Accepts operation commands over a valid/ready interface and queues them. Drives registered operands into the ALU, waits a fixed settle time, then captures the result and flags into an output register with its own valid/ready handshake.
- Sits between the command source (memory-controller sequencer / test driver) and the result consumer.

Parameters:
- DEPTH, 2: command queue entries; power of 2, minimum 2.
- SETTLE, 1: cycles the ALU inputs are held before capture; minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  queue can accept.
- cmd_a  in  16  operand A.
- cmd_b  in  16  operand B.
- cmd_opcode  in  3  ALU opcode.
- cmd_mode  in  1  0 = arithmetic, 1 = logic.
- alu_a  out  16  registered operand to ALU.
- alu_b  out  16  registered operand to ALU.
- alu_opcode  out  3  registered opcode to ALU.
- alu_mode  out  1  registered mode to ALU.
- alu_out  in  32  ALU result.
- alu_flags  in  5  ALU flags {za,zb,eq,gt,lt}.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts.
- res_data  out  32  captured result.
- res_flags  out  5  captured {za,zb,eq,gt,lt}.
- busy  out  1  queue non-empty or FSM not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous)
  - Queue emptied, FSM to IDLE, settle counter cleared.
  - alu_a, alu_b, alu_opcode, alu_mode, res_data, res_flags all 0; res_valid = 0; busy = 0.
  - cmd_ready is forced 0 while rst_n is low. Reset mid-operation discards all queued and in-flight commands; no result is emitted.
- Queue
  - Push on cmd_valid & cmd_ready. cmd_ready = !full, combinational from the registered count.
  - No pass-through: a command pushed into an empty queue is visible to the FSM on the next cycle.
  - Pop and push in the same cycle are permitted when the queue is neither empty nor full; the count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETTLE, RESULT.
  - IDLE: if queue non-empty, pop head into the alu_* registers, load counter = SETTLE, go to SETTLE.
  - SETTLE: decrement counter each cycle. On the cycle the counter equals 1, capture alu_out → res_data and alu_flags → res_flags, set res_valid, go to RESULT.
  - RESULT: res_valid held high; res_data and res_flags stable until the handshake.
    - On res_valid & res_ready: if queue non-empty, pop the next head into alu_* and go to SETTLE (res_valid falls); otherwise clear res_valid and go to IDLE.
    - Without res_ready: stall indefinitely. The queue continues to accept commands until full.
- Latency and throughput
  - Acceptance edge E0 → operands on alu_* after E1 → res_valid high after E(1+SETTLE). With SETTLE = 1, that is 2 cycles.
  - Sustained throughput with res_ready tied high: one result per SETTLE+1 cycles.
- Data handling
  - alu_* registers keep their last values while idle; they change only on a pop.
  - No arithmetic is performed here; the 32-bit result is passed unmodified.
  - Commands complete in acceptance order.

Optional Feature:
- Macro ALU_STICKY_FLAGS_EN.
- Defined: adds input flag_clr (1 bit) and output sticky_flags (5 bits, reset 0).
  - At each capture, sticky_flags |= alu_flags.
  - flag_clr zeroes sticky_flags.
  - flag_clr in the same cycle as a capture: sticky_flags = captured alu_flags (clear, then set).
- Undefined: both ports are absent and there is no sticky logic.

Test Plan:
The bench models the ALU as a stub: alu_out = alu_a + alu_b zero-extended, alu_flags = {a==0, b==0, a==b, a>b, a<b}.
- Single op: a=16'h0003, b=16'h0005, res_ready=1 → res_valid rises 2 cycles after acceptance; res_data=32'h00000008, res_flags=5'b00001; busy returns to 0.
- Back-pressure: res_ready=0, push 3 commands (DEPTH=2) → first result held stable, cmd_ready falls after the queue fills; raise res_ready → results emerge in order with no loss or duplication.
- Throughput: res_ready=1, 8 back-to-back commands a=i, b=i → one res_valid pulse every 2 cycles; res_data=2i; eq flag set on every result.
- Overflow of the operand sum: a=16'hFFFF, b=16'h0001 → res_data=32'h00010000; flags gt=1, zb=0.
- Reset mid-operation: assert rst_n low during SETTLE with 1 entry queued → immediately res_valid=0, alu_a=0, busy=0; after release, no stale result appears.
- ALU_STICKY_FLAGS_EN: ops (0,0) then (5,2) → sticky_flags=5'b11110; pulse flag_clr in the same cycle as a third capture (1,4) → sticky_flags=5'b00001.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller around a combinational ALU: queues commands, drives registered operands,
// waits SETTLE cycles, captures result/flags. Optional sticky flags via ALU_STICKY_FLAGS_EN.
module alu_issue_ctrl #(
    parameter int DEPTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [2:0]  cmd_opcode,
    input  logic        cmd_mode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_opcode,
    output logic        alu_mode,
    input  logic [31:0] alu_out,
    input  logic [4:0]  alu_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_flags,
    output logic        busy
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic        flag_clr,
    output logic [4:0]  sticky_flags
`endif
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(SETTLE + 1);
    localparam int CMD_W = 36;

    localparam logic [PW:0]   CNT_ZERO  = (PW+1)'(0);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL  = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] SET_ZERO  = CW'(0);
    localparam logic [CW-1:0] SET_ONE   = CW'(1);
    localparam logic [CW-1:0] SET_LOAD  = CW'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CMD_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      alu_a_q, alu_a_d;
    logic [15:0]      alu_b_q, alu_b_d;
    logic [2:0]       alu_opcode_q, alu_opcode_d;
    logic             alu_mode_q, alu_mode_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [4:0]       res_flags_q, res_flags_d;
    logic             busy_q, busy_d;

    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             capture_s;
    logic [CMD_W-1:0] head_s;

    assign full_s    = (count_q == CNT_FULL);
    assign cmd_ready = rst_n & ~full_s;
    assign push_s    = cmd_valid & cmd_ready;
    assign head_s    = mem_q[rd_ptr_q];

    // Sequencer: issue from queue, count settle cycles, hold result until consumed
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop_s       = 1'b0;
        capture_s   = 1'b0;
        res_valid_d = res_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != CNT_ZERO) begin
                    pop_s   = 1'b1;
                    cnt_d   = SET_LOAD;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SET_ONE) begin
                    capture_s   = 1'b1;
                    res_valid_d = 1'b1;
                    cnt_d       = SET_ZERO;
                    state_d     = ST_RESULT;
                end else begin
                    cnt_d = cnt_q - SET_ONE;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (count_q != CNT_ZERO) begin
                        pop_s   = 1'b1;
                        cnt_d   = SET_LOAD;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                cnt_d       = SET_ZERO;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Queue storage, pointers and occupancy
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {cmd_mode, cmd_opcode, cmd_b, cmd_a};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Operand and result registers; operands change only on a pop
    always_comb begin
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        alu_mode_d   = alu_mode_q;
        res_data_d   = res_data_q;
        res_flags_d  = res_flags_q;
        if (pop_s) begin
            {alu_mode_d, alu_opcode_d, alu_b_d, alu_a_d} = head_s;
        end else begin
            alu_a_d = alu_a_q;
        end
        if (capture_s) begin
            res_data_d  = alu_out;
            res_flags_d = alu_flags;
        end else begin
            res_data_d = res_data_q;
        end
        busy_d = (count_d != CNT_ZERO) || (state_d != ST_IDLE);
    end

    // State, queue and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {CMD_W{1'b0}};
            end
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            count_q      <= CNT_ZERO;
            state_q      <= ST_IDLE;
            cnt_q        <= SET_ZERO;
            alu_a_q      <= 16'h0000;
            alu_b_q      <= 16'h0000;
            alu_opcode_q <= 3'b000;
            alu_mode_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= 32'h0000_0000;
            res_flags_q  <= 5'b00000;
            busy_q       <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            alu_mode_q   <= alu_mode_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_flags_q  <= res_flags_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_mode   = alu_mode_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_flags  = res_flags_q;
    assign busy       = busy_q;

`ifdef ALU_STICKY_FLAGS_EN
    logic [4:0] sticky_q, sticky_d;

    // Clear takes effect first so a coincident capture still lands
    always_comb begin
        if (flag_clr) begin
            sticky_d = 5'b00000;
        end else begin
            sticky_d = sticky_q;
        end
        if (capture_s) begin
            sticky_d = sticky_d | alu_flags;
        end else begin
            sticky_d = sticky_d;
        end
    end

    // Sticky flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 5'b00000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule
